chunked_adder_sub: RTL and testbench

CHUNKED_ADDER_SUB -- requirements
Module: chunked_adder_sub

---
 rtl/chunked_adder_sub.sv | 95 +++++++++
 tb/tb_chunked_adder_sub.sv | 111 +++++++++++
 2 files changed

// File: rtl/chunked_adder_sub.sv
// chunked_adder_sub: multi-cycle adder/subtractor processing CHUNK bits per clock
module chunked_adder_sub #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             as,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c,
   output logic             ovf,
   output logic             zero
);
   localparam int N  = WIDTH / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_nx;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] ra, rb, acc;
   logic             cy, last, load;
   logic [CHUNK:0]   sum;
   logic [WIDTH+CHUNK-1:0] cat;
   logic [WIDTH-1:0] acc_nx;
   // low chunk of the shifting operands plus running carry; new sum bits enter the result from the top
   always_comb begin
      sum    = {1'b0, ra[CHUNK-1:0]} + {1'b0, rb[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy};
      cat    = {sum[CHUNK-1:0], acc};
      acc_nx = cat[WIDTH+CHUNK-1:CHUNK];
      last   = (k == K_LAST);
   end
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   // next state and status decode
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      load     = 1'b0;
      case (state)
         IDLE: begin
            load = start;
            if (start) state_nx = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            load     = start;
            state_nx = start ? RUN : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   // operand capture, chunk arithmetic, and result/flag update on the final chunk
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ra   <= '0;
         rb   <= '0;
         acc  <= '0;
         cy   <= 1'b0;
         k    <= '0;
         s    <= '0;
         c    <= 1'b0;
         ovf  <= 1'b0;
         zero <= 1'b0;
      end else if (load) begin
         ra  <= a;
         rb  <= b ^ {WIDTH{as}};
         cy  <= as;
         acc <= '0;
         k   <= '0;
      end else if (state == RUN) begin
         ra  <= ra >> CHUNK;
         rb  <= rb >> CHUNK;
         cy  <= sum[CHUNK];
         acc <= acc_nx;
         k   <= k + 1'b1;
         if (last) begin
            s    <= acc_nx;
            c    <= sum[CHUNK];
            ovf  <= ra[CHUNK-1] ^ rb[CHUNK-1] ^ sum[CHUNK-1] ^ sum[CHUNK];
            zero <= (acc_nx == '0);
         end
      end
endmodule

// File: tb/tb_chunked_adder_sub.sv
// tb_chunked_adder_sub: directed checks of the 16/4 chunked adder/subtractor
module tb_chunked_adder_sub;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        as = 1'b0;
   logic        busy, done, c, ovf, zero;
   logic [15:0] s;
   int tests = 0;
   int fails = 0;
   int lat;
   int busy_n;
   int pulses;

   chunked_adder_sub #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .as(as),
      .busy(busy), .done(done), .s(s), .c(c), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // called at a negedge; start is sampled on the following posedge, operands scrambled afterwards
   task automatic go(input logic [15:0] ta, input logic [15:0] tb, input logic tas);
      a = ta; b = tb; as = tas; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; as = ~tas;
      lat = 1;
      busy_n = 0;
   endtask

   // returns at the negedge of the done cycle
   task automatic wait_done(input string tag, input logic [15:0] es, input logic ec,
                            input logic eo, input logic ez);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) break;
         busy_n += int'(busy);
         @(posedge clk);
         lat++;
      end
      chk({tag, "_done"}, {31'd0, done}, 32'd1);
      chk({tag, "_lat"}, lat, 32'd5);
      chk({tag, "_busy"}, busy_n, 32'd4);
      chk({tag, "_s"}, {16'd0, s}, {16'd0, es});
      chk({tag, "_flags"}, {29'd0, c, ovf, zero}, {29'd0, ec, eo, ez});
   endtask

   initial begin
      #2;
      chk("reset_outs", {12'd0, busy, done, s, c, ovf, zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      go(16'h1234, 16'h0FFF, 1'b0);
      wait_done("add", 16'h2233, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("done_pulse_one", {30'd0, done, busy}, 32'd0);
      go(16'h0005, 16'h0007, 1'b1);
      wait_done("sub_borrow", 16'hFFFE, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      go(16'h7FFF, 16'h0001, 1'b0);
      wait_done("ovf_add", 16'h8000, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      go(16'h8000, 16'h0001, 1'b1);
      wait_done("ovf_sub", 16'h7FFF, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      go(16'h1234, 16'h1234, 1'b1);
      wait_done("equal", 16'h0000, 1'b1, 1'b0, 1'b1);
      go(16'hFFFF, 16'h0001, 1'b0);
      wait_done("b2b", 16'h0000, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      go(16'h1111, 16'h2222, 1'b0);
      @(negedge clk);
      busy_n += int'(busy);
      a = 16'hAAAA; b = 16'h5555; as = 1'b1; start = 1'b1;
      @(posedge clk);
      lat++;
      #1 start = 1'b0;
      wait_done("run_start", 16'h3333, 1'b0, 1'b0, 1'b0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         pulses += int'(done);
      end
      chk("run_start_pulses", pulses, 32'd0);
      go(16'h00FF, 16'h0F01, 1'b0);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("async_reset", {12'd0, busy, done, s, c, ovf, zero}, 32'd0);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         pulses += int'(done) + int'(busy);
      end
      chk("reset_no_done", pulses, 32'd0);
      rst_n = 1'b1;
      go(16'h0001, 16'h0001, 1'b0);
      wait_done("after_reset", 16'h0002, 1'b0, 1'b0, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
